// File: rtl/hilo_div_ctrl.sv
// EX-stage HI/LO sequencer: issues DIV/DIVU to the multi-cycle divider, stalls while it runs,
// and captures {remainder, quotient} into HI/LO. Define HILO_FWD_EN to forward HI/LO writes same-cycle.
module hilo_div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);
    localparam int CW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   op1_d, op2_d;
    logic          start_d, signed_d;
    logic          is_div, is_mthi, is_mtlo;

    assign is_div  = op_valid_i && (op_i == OP_DIV || op_i == OP_DIVU);
    assign is_mthi = op_valid_i && (op_i == OP_MTHI);
    assign is_mtlo = op_valid_i && (op_i == OP_MTLO);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        op1_d       = div_op1_o;
        op2_d       = div_op2_o;
        start_d     = div_start_o;
        signed_d    = div_signed_o;
        stall_o     = 1'b0;
        div_annul_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_i) begin
                    if (is_div) begin
                        stall_o  = 1'b1;
                        op1_d    = rs_i;
                        op2_d    = rt_i;
                        signed_d = (op_i == OP_DIV);
                        start_d  = 1'b1;
                        state_d  = S_WAIT;
                    end else if (is_mthi) begin
                        hi_d = rs_i;
                    end else if (is_mtlo) begin
                        lo_d = rs_i;
                    end
                end
            end
            S_WAIT: begin
                stall_o = !div_ready_i && !flush_i;
                // Flush wins over a same-cycle ready: the result is dropped and the divider annulled.
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    start_d     = 1'b0;
                    cnt_d       = DRAIN_LOAD;
                    state_d     = S_DRAIN;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                stall_o = is_div;
                start_d = 1'b0;
                if (!flush_i) begin
                    if (is_mthi)      hi_d = rs_i;
                    else if (is_mtlo) lo_d = rs_i;
                end
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            div_op1_o    <= op1_d;
            div_op2_o    <= op2_d;
            div_start_o  <= start_d;
            div_signed_o <= signed_d;
        end
    end

`ifdef HILO_FWD_EN
    assign hi_o = hi_d;
    assign lo_o = lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: behavioural divider on the far side, vector table, corner sequences, random ops.
module tb_hilo_div_ctrl;
    localparam logic [2:0] DIV = 3'b001, DIVU = 3'b010, MTHI = 3'b011, MTLO = 3'b100;

    logic        clk, rst;
    logic        op_valid_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs_i, rt_i;
    logic        stall_o, div_start_o, div_annul_o, div_signed_o;
    logic [31:0] hi_o, lo_o, div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    hilo_div_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
        .flush_i(flush_i), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int lat = 4;
    logic [31:0] hi_m = '0, lo_m = '0;

    // {remainder, quotient}, truncating division; divide-by-zero reports 0/0
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        int unsigned ua, ub;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a; sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        ua = a; ub = b;
        return {ua % ub, ua / ub};
    endfunction

    // Divider: latency 'lat' after seeing start while free; annul returns it to free;
    // after finishing it must see start low before accepting another.
    logic        d_busy, d_done, d_sgn;
    int          d_cnt;
    logic [31:0] d_a, d_b;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_busy <= 1'b0; d_done <= 1'b0; d_cnt <= 0; d_sgn <= 1'b0;
            d_a <= '0; d_b <= '0; div_ready_i <= 1'b0; div_result_i <= '0;
        end else begin
            div_ready_i <= 1'b0;
            if (div_annul_o) begin
                d_busy <= 1'b0; d_done <= 1'b0;
            end else if (d_busy) begin
                if (d_cnt <= 1) begin
                    div_ready_i  <= 1'b1;
                    div_result_i <= ref_div(d_sgn, d_a, d_b);
                    d_busy <= 1'b0; d_done <= 1'b1;
                end else d_cnt <= d_cnt - 1;
            end else if (d_done) begin
                if (!div_start_o) d_done <= 1'b0;
            end else if (div_start_o) begin
                d_busy <= 1'b1; d_cnt <= lat;
                d_a <= div_op1_o; d_b <= div_op2_o; d_sgn <= div_signed_o;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Present one EX instruction, holding it while stalled; flush_i pulses in cycle flush_at (-1: never).
    task automatic run_instr(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input int flush_at, output bit retired, output logic ann);
        logic st;
        bit   done, is_d;
        retired = 0; ann = 1'b0; done = 0;
        is_d = v && (op == DIV || op == DIVU);
        @(negedge clk);
        op_valid_i = v; op_i = op; rs_i = rs; rt_i = rt;
        for (int k = 0; k < 400 && !done; k++) begin
            if (k > 0) @(negedge clk);
            flush_i = (k == flush_at);
            #1;
            st = stall_o;
            if (k == 0 && !flush_i) begin
                chk("stall_first", st, is_d);
`ifdef HILO_FWD_EN
                if (v && op == MTHI) chk("hi_fwd", hi_o, rs);
                if (v && op == MTLO) chk("lo_fwd", lo_o, rs);
`else
                if (v && op == MTHI) chk("hi_nofwd", hi_o, hi_m);
                if (v && op == MTLO) chk("lo_nofwd", lo_o, lo_m);
`endif
            end
            if (flush_i) ann = div_annul_o;
            else chk("annul_quiet", div_annul_o, 1'b0);
            @(posedge clk);
            if (flush_i) done = 1;
            else if (!st) begin done = 1; retired = 1; end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: op %0d never retired", op);
        end
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, exp_hi, exp_lo;
    } vec_t;

    vec_t        tbl[11];
    bit          r;
    logic        a, v;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic [63:0] res;
    int          fa;
    bit          got;

    initial begin
        rst = 1'b0; op_valid_i = 1'b0; op_i = '0; rs_i = '0; rt_i = '0; flush_i = 1'b0;
        tbl[0]  = '{MTHI, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{MTLO, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678};
        tbl[2]  = '{3'b000, 32'h55, 32'h0, 32'hDEADBEEF, 32'h12345678};
        tbl[3]  = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4]  = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[5]  = '{DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF};
        tbl[6]  = '{DIV, 32'd9, 32'd2, 32'd1, 32'd4};
        tbl[7]  = '{DIV, 32'd5, 32'd0, 32'd0, 32'd0};
        tbl[8]  = '{3'b111, 32'h77, 32'h1, 32'd0, 32'd0};
        tbl[9]  = '{DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA};
        tbl[10] = '{DIVU, 32'hFFFFFFEC, 32'd3, 32'd2, 32'h5555554E};

        #12;
        chk("rst_hi", hi_o, 0); chk("rst_lo", lo_o, 0); chk("rst_start", div_start_o, 0);
        chk("rst_signed", div_signed_o, 0); chk("rst_op1", div_op1_o, 0); chk("rst_op2", div_op2_o, 0);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_stall", stall_o, 0);

        // Vector table, applied back to back (entries 4/5 are consecutive divides)
        lat = 3;
        for (int i = 0; i < 11; i++) begin
            run_instr(1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt, -1, r, a);
            chk("tbl_retired", r, 1);
            chk($sformatf("tbl%0d_hi", i), hi_o, tbl[i].exp_hi);
            chk($sformatf("tbl%0d_lo", i), lo_o, tbl[i].exp_lo);
            if (tbl[i].op == DIV || tbl[i].op == DIVU) begin
                chk("tbl_start_drop", div_start_o, 0);
                chk("tbl_signed", div_signed_o, tbl[i].op == DIV);
                chk("tbl_op1", div_op1_o, tbl[i].rs);
            end
            hi_m = tbl[i].exp_hi; lo_m = tbl[i].exp_lo;
        end

        // Flush five cycles into a long divide, MTLO during drain, then DIV 9/2 must wait out the drain
        lat = 10;
        run_instr(1'b1, MTHI, 32'hCAFE0001, 0, -1, r, a); hi_m = 32'hCAFE0001;
        run_instr(1'b1, DIV, 32'd1000, 32'd3, 5, r, a);
        chk("fl_killed", r, 0); chk("fl_annul", a, 1);
        chk("fl_annul_1cyc", div_annul_o, 0); chk("fl_start", div_start_o, 0);
        chk("fl_hi", hi_o, hi_m); chk("fl_lo", lo_o, lo_m);
        run_instr(1'b1, MTLO, 32'hA5A5A5A5, 0, -1, r, a);
        lo_m = 32'hA5A5A5A5;
        chk("drain_mtlo", lo_o, lo_m);
        @(negedge clk); op_i = DIV; rs_i = 32'd9; rt_i = 32'd2; flush_i = 1'b0; #1;
        chk("drain2_stall", stall_o, 1);
        @(posedge clk); #1; chk("drain2_nostart", div_start_o, 0);
        @(negedge clk); #1; chk("idle_stall", stall_o, 1);
        @(posedge clk); #1; chk("issue_after_drain", div_start_o, 1);
        run_instr(1'b1, DIV, 32'd9, 32'd2, -1, r, a);
        hi_m = 32'd1; lo_m = 32'd4;
        chk("post_drain_hi", hi_o, hi_m); chk("post_drain_lo", lo_o, lo_m);

        // Flush in the same cycle as ready: no capture, drain entered
        lat = 3;
        @(negedge clk); op_valid_i = 1'b1; op_i = DIV; rs_i = 32'd8; rt_i = 32'd3; flush_i = 1'b0;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (div_ready_i) got = 1;
            else @(negedge clk);
        end
        if (!got) begin n_cmp++; n_bad++; $display("FAIL ready_timeout: no div_ready_i"); end
        flush_i = 1'b1; #1;
        chk("rdyfl_annul", div_annul_o, 1); chk("rdyfl_stall", stall_o, 0);
        @(posedge clk); #1;
        chk("rdyfl_hi", hi_o, hi_m); chk("rdyfl_lo", lo_o, lo_m);
        @(negedge clk); flush_i = 1'b0; #1;
        chk("rdyfl_drain_stall", stall_o, 1); chk("rdyfl_drain_start", div_start_o, 0);
        run_instr(1'b1, DIV, 32'd8, 32'd3, -1, r, a);
        hi_m = 32'd2; lo_m = 32'd2;
        chk("rdyfl_after_hi", hi_o, hi_m); chk("rdyfl_after_lo", lo_o, lo_m);

        // Asynchronous reset in the middle of a divide
        lat = 10;
        @(negedge clk); op_valid_i = 1'b1; op_i = DIVU; rs_i = 32'd50; rt_i = 32'd5;
        repeat (3) @(negedge clk);
        chk("mid_wait_start", div_start_o, 1);
        #2 rst = 1'b0; #1;
        chk("arst_start", div_start_o, 0); chk("arst_hi", hi_o, 0); chk("arst_lo", lo_o, 0);
        @(negedge clk); op_valid_i = 1'b0; rst = 1'b1; #1;
        chk("arst_stall", stall_o, 0);
        hi_m = '0; lo_m = '0;

        // Random ops against the HI/LO model
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op = ($urandom_range(0, 1) != 0) ? DIV : DIVU;
                5, 6:          op = MTHI;
                7, 8:          op = MTLO;
                default:       op = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'(3'd5 + 3'($urandom_range(0, 2)));
            endcase
            rs = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = 32'd0;
                1:       rt = $urandom_range(1, 15);
                2:       rt = 32'hFFFFFFFF;
                default: rt = $urandom;
            endcase
            if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'd1;
            fa  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1;
            lat = $urandom_range(1, 6);
            run_instr(v, op, rs, rt, fa, r, a);
            if (r && v) begin
                if (op == DIV || op == DIVU) begin
                    res = ref_div(op == DIV, rs, rt);
                    hi_m = res[63:32]; lo_m = res[31:0];
                end else if (op == MTHI) hi_m = rs;
                else if (op == MTLO) lo_m = rs;
            end
            chk("rnd_hi", hi_o, hi_m);
            chk("rnd_lo", lo_o, lo_m);
        end

        @(negedge clk); op_valid_i = 1'b0; flush_i = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
